// File: rtl/mobo_bus_ctrl.sv
// Motherboard bus controller: decodes CPU requests onto the RAM/VGA shared bus,
// runs the ctrl/stat handshake with the selected device and reports completion.
module mobo_bus_ctrl #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] cpu_ctrl,
  output logic [WORD_WIDTH-1:0] cpu_stat,
  input  logic [WORD_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic [WORD_WIDTH-1:0] ram_ctrl,
  input  logic [WORD_WIDTH-1:0] ram_stat,
  output logic [WORD_WIDTH-1:0] vga_ctrl,
  input  logic [WORD_WIDTH-1:0] vga_stat,
  output logic [WORD_WIDTH-1:0] addr,
  output logic [WORD_WIDTH-1:0] data_out,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [2:0]            dbg_state
);

  // Handshake: a device ctrl word is held non-zero until that device's stat
  // bit1 (DONE) is sampled high; the CPU holds cpu_ctrl until it sees DONE in
  // cpu_stat and then drops it to 0 to release the controller.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAM_RD = 3'd1,
    S_RAM_WR = 3'd2,
    S_VGA_RD = 3'd3,
    S_VGA_WR = 3'd4,
    S_ERR    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [WORD_WIDTH-1:0] CMD_RD   = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] CMD_WR   = WORD_WIDTH'(2);
  localparam logic [WORD_WIDTH-1:0] ST_IDLE  = WORD_WIDTH'(0);
  localparam logic [WORD_WIDTH-1:0] ST_BUSY  = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] ST_DONE  = WORD_WIDTH'(2);
  localparam logic [WORD_WIDTH-1:0] ST_DERR  = WORD_WIDTH'(6);

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] cpu_stat_q, cpu_stat_d;
  logic [WORD_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WORD_WIDTH-1:0] ram_ctrl_q, ram_ctrl_d;
  logic [WORD_WIDTH-1:0] vga_ctrl_q, vga_ctrl_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_out_q, data_out_d;

  logic                  is_ram, is_vga, is_rd, start;
  logic [WORD_WIDTH-1:0] local_addr;
  logic                  unused_stat;

  assign is_ram = (cpu_addr[31:20] == 12'h000);
  assign is_vga = (cpu_addr[31:16] == 16'h8000);
  assign is_rd  = cpu_ctrl[0];
  assign start  = cpu_ctrl[0] | cpu_ctrl[1];
  assign unused_stat = ^{ram_stat[WORD_WIDTH-1:2], ram_stat[0],
                         vga_stat[WORD_WIDTH-1:2], vga_stat[0]};

  always_comb begin
    local_addr = '0;
    if (is_ram)      local_addr = cpu_addr;
    else if (is_vga) local_addr = {16'h0000, cpu_addr[15:0]};
  end

  always_comb begin
    state_d     = state_q;
    cpu_stat_d  = cpu_stat_q;
    cpu_rdata_d = cpu_rdata_q;
    ram_ctrl_d  = ram_ctrl_q;
    vga_ctrl_d  = vga_ctrl_q;
    addr_d      = addr_q;
    data_out_d  = data_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cpu_stat_d = ST_BUSY;
          addr_d     = local_addr;
          data_out_d = cpu_wdata;
          if (is_ram) begin
            state_d    = is_rd ? S_RAM_RD : S_RAM_WR;
            ram_ctrl_d = is_rd ? CMD_RD : CMD_WR;
          end else if (is_vga) begin
            state_d    = is_rd ? S_VGA_RD : S_VGA_WR;
            vga_ctrl_d = is_rd ? CMD_RD : CMD_WR;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_RAM_RD, S_RAM_WR: begin
        if (ram_stat[1]) begin
          ram_ctrl_d = '0;
          cpu_stat_d = ST_DONE;
          if (state_q == S_RAM_RD) cpu_rdata_d = data_in;
          state_d = S_DONE;
        end
      end
      S_VGA_RD, S_VGA_WR: begin
        if (vga_stat[1]) begin
          vga_ctrl_d = '0;
          cpu_stat_d = ST_DONE;
          if (state_q == S_VGA_RD) cpu_rdata_d = data_in;
          state_d = S_DONE;
        end
      end
      S_ERR: begin
        cpu_stat_d = ST_DERR;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (cpu_ctrl == '0) begin
          cpu_stat_d = ST_IDLE;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cpu_stat_q  <= '0;
      cpu_rdata_q <= '0;
      ram_ctrl_q  <= '0;
      vga_ctrl_q  <= '0;
      addr_q      <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      cpu_stat_q  <= cpu_stat_d;
      cpu_rdata_q <= cpu_rdata_d;
      ram_ctrl_q  <= ram_ctrl_d;
      vga_ctrl_q  <= vga_ctrl_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
    end
  end

  assign cpu_stat  = cpu_stat_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ram_ctrl  = ram_ctrl_q;
  assign vga_ctrl  = vga_ctrl_q;
  assign addr      = addr_q;
  assign data_out  = data_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mobo_bus_ctrl.sv
// Bench for mobo_bus_ctrl: directed transaction vectors drive the CPU side and
// play the device side; a monitor checks each reported completion against a queue.
module tb_mobo_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_ctrl, cpu_addr, cpu_wdata, ram_stat, vga_stat, data_in;
  logic [31:0] cpu_stat, cpu_rdata, ram_ctrl, vga_ctrl, addr, data_out;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_stat_q[$];
  logic [31:0] exp_rdata_q[$];
  logic [31:0] rdata_model;

  typedef struct {
    logic [31:0] cmd, a, wdata, dat, loc, devctrl;
    int          tgt;   // 0 = RAM, 1 = VGA, 2 = unmapped
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  mobo_bus_ctrl #(.WORD_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_ctrl(cpu_ctrl), .cpu_stat(cpu_stat), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ram_ctrl(ram_ctrl), .ram_stat(ram_stat),
    .vga_ctrl(vga_ctrl), .vga_stat(vga_stat),
    .addr(addr), .data_out(data_out), .data_in(data_in),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: every rising DONE bit on cpu_stat must match the next expectation
  initial begin : monitor
    logic prev_done;
    logic [31:0] es, er;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (cpu_stat[1] && !prev_done) begin
          if (exp_stat_q.size() == 0) begin
            chk("unexpected_done", cpu_stat, 32'h0);
          end else begin
            es = exp_stat_q.pop_front();
            er = exp_rdata_q.pop_front();
            chk("sb_stat", cpu_stat, es);
            chk("sb_rdata", cpu_rdata, er);
          end
        end
        prev_done = cpu_stat[1];
      end
    end
  end

  function automatic vec_t mk(logic [31:0] cmd, logic [31:0] a, logic [31:0] wdata,
                              logic [31:0] dat, int tgt, logic [31:0] loc,
                              logic [31:0] devctrl, int lat, int hold);
    vec_t v;
    v.cmd = cmd; v.a = a; v.wdata = wdata; v.dat = dat; v.tgt = tgt;
    v.loc = loc; v.devctrl = devctrl; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // driver: one full transaction, device side included; starts and ends on a negedge
  task automatic run_vec(input vec_t v);
    logic [31:0] exp_ram, exp_vga;
    exp_ram = (v.tgt == 0) ? v.devctrl : 32'h0;
    exp_vga = (v.tgt == 1) ? v.devctrl : 32'h0;
    cpu_ctrl  = v.cmd;
    cpu_addr  = v.a;
    cpu_wdata = v.wdata;
    data_in   = v.dat;
    if (v.tgt != 2 && v.devctrl == 32'h1) rdata_model = v.dat;
    exp_stat_q.push_back((v.tgt == 2) ? 32'h6 : 32'h2);
    exp_rdata_q.push_back(rdata_model);
    @(negedge clk);
    chk("busy", cpu_stat, 32'h1);
    chk("ram_ctrl", ram_ctrl, exp_ram);
    chk("vga_ctrl", vga_ctrl, exp_vga);
    chk("addr", addr, v.loc);
    chk("data_out", data_out, v.wdata);
    cpu_addr  = ~v.a;
    cpu_wdata = ~v.wdata;
    data_in   = ~v.dat;
    if (v.tgt == 2) begin
      @(negedge clk);
      chk("err_ctrl", ram_ctrl | vga_ctrl, 32'h0);
    end else begin
      for (int i = 0; i < v.lat; i++) begin
        @(negedge clk);
        chk("hold_ctrl", ram_ctrl | vga_ctrl, v.devctrl);
        chk("hold_addr", addr, v.loc);
        chk("hold_data", data_out, v.wdata);
      end
      data_in = v.dat;
      if (v.tgt == 0) ram_stat = 32'h2;
      else            vga_stat = 32'h2;
      @(negedge clk);
      ram_stat = 32'h0;
      vga_stat = 32'h0;
      chk("ctrl_cleared", ram_ctrl | vga_ctrl, 32'h0);
      data_in = 32'h0;
    end
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("done_hold", cpu_stat, (v.tgt == 2) ? 32'h6 : 32'h2);
      chk("no_reaccess", ram_ctrl | vga_ctrl, 32'h0);
    end
    cpu_ctrl = 32'h0;
    @(negedge clk);
    chk("release", cpu_stat, 32'h0);
    chk("release_state", {29'h0, dbg_state}, 32'h0);
  endtask

  initial begin : stim
    vecs[0] = mk(32'h2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 32'h10, 32'h2, 3, 0);
    vecs[1] = mk(32'h1, 32'h8000_0040, 32'h0, 32'h1234_5678, 1, 32'h40, 32'h1, 0, 0);
    vecs[2] = mk(32'h1, 32'h4000_0000, 32'h0, 32'h5555_AAAA, 2, 32'h0, 32'h1, 0, 0);
    vecs[3] = mk(32'h3, 32'h0000_0100, 32'h0, 32'hA5A5_0001, 0, 32'h100, 32'h1, 1, 5);
    vecs[4] = mk(32'h1, 32'h000F_FFFC, 32'h0, 32'hCAFE_0001, 0, 32'hF_FFFC, 32'h1, 2, 0);
    vecs[5] = mk(32'h2, 32'h0010_0000, 32'h0000_0077, 32'h0, 2, 32'h0, 32'h2, 0, 2);
    vecs[6] = mk(32'h2, 32'h8000_FFFF, 32'h0BAD_F00D, 32'h0, 1, 32'hFFFF, 32'h2, 1, 0);
    vecs[7] = mk(32'h1, 32'h8001_0000, 32'h0, 32'h9999_0000, 2, 32'h0, 32'h1, 0, 0);
    vecs[8] = mk(32'hFFFF_FFF1, 32'h0000_0020, 32'h0, 32'h1111_2222, 0, 32'h20, 32'h1, 0, 0);

    rst = 1'b1; cpu_ctrl = 0; cpu_addr = 0; cpu_wdata = 0;
    ram_stat = 0; vga_stat = 0; data_in = 0; rdata_model = 0;
    #2;
    chk("rst_outs", cpu_stat | cpu_rdata | ram_ctrl | vga_ctrl | addr | data_out, 32'h0);
    chk("rst_state", {29'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", cpu_stat | ram_ctrl | vga_ctrl, 32'h0);
    end

    // control bits outside READ/WRITE alone never start a transaction
    cpu_ctrl = 32'h4; cpu_addr = 32'h10;
    repeat (3) @(negedge clk);
    chk("no_start", cpu_stat | ram_ctrl | vga_ctrl, 32'h0);
    cpu_ctrl = 32'h0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // reset while RAM_RD waits: ctrl must drop without waiting for a clock edge
    cpu_ctrl = 32'h1; cpu_addr = 32'h30;
    @(negedge clk);
    chk("pre_rst_ctrl", ram_ctrl, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_ctrl", ram_ctrl, 32'h0);
    chk("async_stat", cpu_stat, 32'h0);
    rdata_model = 32'h0;
    @(negedge clk);
    rst = 1'b0; cpu_ctrl = 32'h0;
    @(negedge clk);
    chk("post_rst_stat", cpu_stat, 32'h0);
    chk("post_rst_state", {29'h0, dbg_state}, 32'h0);
    run_vec(vecs[1]);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_stat_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
